geogenius_param: RTL and testbench
==================================

// Module: geogenius_param
// PURPOSE
// - Parametrised next-generation Genius/Simon memory-game core: N_BOTOES buttons/LEDs, rounds of growing length up to PROFUNDIDADE.
// - Sequence built on-chip from a free-running LFSR; each round replays the sequence on leds, then checks the player's presses.
// - Player has a per-press timeout and a difficulty mode. Control FSM and datapath live in one block.
// - Drives the board top-level; score and db_estado feed hexa7seg displays there.
// PARAMETERS
// - N_BOTOES       8       number of buttons/LEDs; power of two, 2..16
// - PROFUNDIDADE   16      rounds to win = max sequence length; 2..32
// - TEMPO_LED      1000    cycles each LED stays lit during replay
// - TEMPO_APAGADO  500     cycles all LEDs are dark between replayed elements
// - TEMPO_JOGADA   5000    cycles allowed per press before timeout
// - SEMENTE        16'hACE1 LFSR reset value; must be nonzero
// PORTS
// - clock        in   1                      single clock, rising edge
// - reset        in   1                      synchronous, active-high
// - jogar        in   1                      start/restart game (level, sampled each cycle)
// - dificuldade  in   1                      1 = all three timers halved (>>1); sampled when jogar accepted
// - botoes       in   N_BOTOES               player buttons, already debounced/synchronised
// - leds         out  N_BOTOES               one-hot during replay and press echo, else 0
// - score        out  $clog2(PROFUNDIDADE+1) rounds completed, binary
// - pronto       out  1                      game over (any result)
// - ganhou       out  1                      all PROFUNDIDADE rounds completed
// - perdeu       out  1                      wrong press
// - timeout      out  1                      no press within timer
// - db_estado    out  4                      FSM state code
// BEHAVIOUR
// - Reset: state INICIAL, leds=0, score=0, pronto=ganhou=perdeu=timeout=0, timers/counters=0, LFSR=SEMENTE; reset mid-game aborts same edge.
// - LFSR: 16-bit Galois, taps 0xB400, advances every cycle from reset. Memory: PROFUNDIDADE x log2(N_BOTOES) registers.
// - Press event: rising edge of |botoes (registered previous OR). Valid only if botoes one-hot; non-one-hot press = wrong press.
// - States/codes: INICIAL 0, PREPARA 1, ACRESCENTA 2, MOSTRA 3, APAGADO 4, ESPERA 5, COMPARA 6, PROXIMA 7, FIM_RODADA 8, GANHOU A, PERDEU B, TIMEOUT C.
// - INICIAL --jogar--> PREPARA: score=0, round length k=0, latch dificuldade.
// - PREPARA -> ACRESCENTA: mem[k] <= LFSR[log2N-1:0]; k++. -> MOSTRA with index i=0.
// - MOSTRA: leds=onehot(mem[i]) for TEMPO_LED cycles -> APAGADO (leds=0) for TEMPO_APAGADO; then i++ -> MOSTRA, or after i=k-1 -> ESPERA with i=0.
// - ESPERA: timer runs; press event -> COMPARA (1-cycle latency); timer reaches TEMPO_JOGADA with no press -> TIMEOUT. Press and expiry same cycle: press wins.
// - ESPERA: leds echo botoes while held. Presses during MOSTRA/APAGADO ignored; a button held across the ESPERA entry requires release+repress.
// - COMPARA: match -> PROXIMA (i++, timer cleared) if i<k-1, else FIM_RODADA; mismatch -> PERDEU.
// - FIM_RODADA: score++; if k==PROFUNDIDADE -> GANHOU else -> ACRESCENTA.
// - GANHOU/PERDEU/TIMEOUT: pronto=1 plus matching flag, held; score held; jogar -> PREPARA (flags cleared same edge).
// - jogar ignored in all non-idle, non-terminal states. Counters saturate, never wrap; score never exceeds PROFUNDIDADE.
// CONFIGURATION
// - GEOGENIUS_VIDAS_EN defined: 3 lives (2-bit counter, reset/jogar -> 3). Wrong press or timeout with lives>1: lives--, replay current round (-> MOSTRA, i=0, no new element, score unchanged); with lives==1 -> PERDEU/TIMEOUT.
//   Extra output vidas [1:0] present only with macro.
// - Undefined: first error ends game; no vidas port.
// TESTING
// - reset mid-MOSTRA, release -> all outputs 0, db_estado=0, LFSR restarts at SEMENTE (replay matches golden model).
// - Defaults, jogar, correct presses per model for 16 rounds -> score=16, ganhou=1, pronto=1; then jogar -> score=0, flags clear.
// - Round 3, second press wrong -> perdeu=1, pronto=1, score=2, leds=0.
// - dificuldade=1, no press in ESPERA -> timeout=1 exactly 2500 cycles after ESPERA entry.
// - Two buttons pressed same cycle in ESPERA -> perdeu=1; button held from replay into ESPERA -> no COMPARA until repress.
// - GEOGENIUS_VIDAS_EN: three wrong presses in round 1 -> two replays, vidas 3->2->1, then perdeu=1, score=0.

Source files
------------

// File: rtl/geogenius_param_if.sv
// Player/board bundle for geogenius_param: controls in, lamps/status out.
// vidas exists only when GEOGENIUS_VIDAS_EN is defined.
interface geogenius_param_if #(
  parameter int N_BOTOES     = 8,
  parameter int PROFUNDIDADE = 16
);
  localparam int SW = $clog2(PROFUNDIDADE + 1);

  logic                jogar;
  logic                dificuldade;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic [SW-1:0]       score;
  logic                pronto;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic [3:0]          db_estado;
`ifdef GEOGENIUS_VIDAS_EN
  logic [1:0]          vidas;

  modport master (
    output jogar, dificuldade, botoes,
    input  leds, score, pronto, ganhou,
    input  perdeu, timeout, db_estado, vidas
  );
  modport slave (
    input  jogar, dificuldade, botoes,
    output leds, score, pronto, ganhou,
    output perdeu, timeout, db_estado, vidas
  );
`else
  modport master (
    output jogar, dificuldade, botoes,
    input  leds, score, pronto, ganhou,
    input  perdeu, timeout, db_estado
  );
  modport slave (
    input  jogar, dificuldade, botoes,
    output leds, score, pronto, ganhou,
    output perdeu, timeout, db_estado
  );
`endif
endinterface

// File: rtl/geogenius_param.sv
// Genius/Simon memory-game core: LFSR-built sequence, replay, press check.
// Ports: clock, reset (sync, active-high), bus (geogenius_param_if.slave).
// Macro GEOGENIUS_VIDAS_EN adds three lives and the bus.vidas output.
module geogenius_param #(
  parameter int          N_BOTOES      = 8,
  parameter int          PROFUNDIDADE  = 16,
  parameter int          TEMPO_LED     = 1000,
  parameter int          TEMPO_APAGADO = 500,
  parameter int          TEMPO_JOGADA  = 5000,
  parameter logic [15:0] SEMENTE       = 16'hACE1
) (
  input logic              clock,
  input logic              reset,
  geogenius_param_if.slave bus
);
  localparam int LG = $clog2(N_BOTOES);
  localparam int IW = $clog2(PROFUNDIDADE);
  localparam int SW = $clog2(PROFUNDIDADE + 1);
  localparam int TA = (TEMPO_LED > TEMPO_APAGADO) ? TEMPO_LED : TEMPO_APAGADO;
  localparam int TM = (TA > TEMPO_JOGADA) ? TA : TEMPO_JOGADA;
  localparam int TW = $clog2(TM + 1);

  typedef enum logic [3:0] {
    E_INICIAL    = 4'h0,
    E_PREPARA    = 4'h1,
    E_ACRESCENTA = 4'h2,
    E_MOSTRA     = 4'h3,
    E_APAGADO    = 4'h4,
    E_ESPERA     = 4'h5,
    E_COMPARA    = 4'h6,
    E_PROXIMA    = 4'h7,
    E_FIM_RODADA = 4'h8,
    E_GANHOU     = 4'hA,
    E_PERDEU     = 4'hB,
    E_TIMEOUT    = 4'hC
  } estado_t;

  estado_t             r_estado;
  logic [15:0]         r_lfsr;
  logic [LG-1:0]       r_mem [PROFUNDIDADE];
  logic [SW-1:0]       r_k;
  logic [SW-1:0]       r_i;
  logic [TW-1:0]       r_timer;
  logic                r_dif;
  logic                r_prev_or;
  logic                r_press_ok;
  logic [LG-1:0]       r_press_idx;
  logic [N_BOTOES-1:0] r_leds;
  logic [SW-1:0]       r_score;
  logic                r_pronto;
  logic                r_ganhou;
  logic                r_perdeu;
  logic                r_timeout;

  logic [15:0]   w_lfsr_nxt;
  logic [LG-1:0] w_new;
  logic [LG-1:0] w_idx;
  logic          w_press;
  logic          w_onehot;
  logic          w_start;
  logic          w_last;
  logic          w_match;
  logic          w_expira;
  logic          w_erro;
  logic          w_replay;
  logic [SW-1:0] w_i_nxt;
  logic [TW-1:0] w_t_led;
  logic [TW-1:0] w_t_apag;
  logic [TW-1:0] w_t_jog;

  function automatic logic [N_BOTOES-1:0] f_onehot(
    input logic [LG-1:0] v
  );
    f_onehot    = '0;
    f_onehot[v] = 1'b1;
  endfunction

  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                    ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_new   = r_lfsr[LG-1:0];
  assign w_press = (|bus.botoes) & ~r_prev_or;
  assign w_onehot = (bus.botoes != '0)
    && ((bus.botoes & (bus.botoes - 1'b1)) == '0);

  always_comb begin
    w_idx = '0;
    for (int b = 0; b < N_BOTOES; b++)
      if (bus.botoes[b]) w_idx = LG'(b);
  end

  assign w_t_led  = r_dif ? TW'(TEMPO_LED >> 1) : TW'(TEMPO_LED);
  assign w_t_apag = r_dif ? TW'(TEMPO_APAGADO >> 1) : TW'(TEMPO_APAGADO);
  assign w_t_jog  = r_dif ? TW'(TEMPO_JOGADA >> 1) : TW'(TEMPO_JOGADA);

  assign w_i_nxt = r_i + SW'(1);
  assign w_last  = (r_i == r_k - SW'(1));
  assign w_match = r_press_ok && (r_press_idx == r_mem[r_i[IW-1:0]]);
  assign w_start = bus.jogar && (r_estado inside
    {E_INICIAL, E_GANHOU, E_PERDEU, E_TIMEOUT});
  // A press on the expiry cycle wins over the timeout.
  assign w_expira = (r_estado == E_ESPERA) && !w_press
    && (r_timer >= w_t_jog - TW'(1));
  assign w_erro = w_expira || ((r_estado == E_COMPARA) && !w_match);

`ifdef GEOGENIUS_VIDAS_EN
  logic [1:0] r_vidas;
  assign w_replay  = (r_vidas > 2'd1);
  assign bus.vidas = r_vidas;
`else
  assign w_replay = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= E_INICIAL;
      r_lfsr      <= SEMENTE;
      r_k         <= '0;
      r_i         <= '0;
      r_timer     <= '0;
      r_dif       <= 1'b0;
      r_prev_or   <= 1'b0;
      r_press_ok  <= 1'b0;
      r_press_idx <= '0;
      r_leds      <= '0;
      r_score     <= '0;
      r_pronto    <= 1'b0;
      r_ganhou    <= 1'b0;
      r_perdeu    <= 1'b0;
      r_timeout   <= 1'b0;
      for (int n = 0; n < PROFUNDIDADE; n++) r_mem[n] <= '0;
`ifdef GEOGENIUS_VIDAS_EN
      r_vidas     <= 2'd3;
`endif
    end else begin
      r_lfsr    <= w_lfsr_nxt;
      r_prev_or <= |bus.botoes;
      r_leds    <= '0;
      if (w_start) begin
        r_estado  <= E_PREPARA;
        r_score   <= '0;
        r_k       <= '0;
        r_i       <= '0;
        r_timer   <= '0;
        r_dif     <= bus.dificuldade;
        r_pronto  <= 1'b0;
        r_ganhou  <= 1'b0;
        r_perdeu  <= 1'b0;
        r_timeout <= 1'b0;
`ifdef GEOGENIUS_VIDAS_EN
        r_vidas   <= 2'd3;
`endif
      end else if (w_erro) begin
        r_i     <= '0;
        r_timer <= '0;
        if (w_replay) begin
          // Lose a life and replay the same round.
          r_leds   <= f_onehot(r_mem[0]);
          r_estado <= E_MOSTRA;
`ifdef GEOGENIUS_VIDAS_EN
          r_vidas  <= r_vidas - 2'd1;
`endif
        end else begin
          r_pronto  <= 1'b1;
          r_timeout <= (r_estado == E_ESPERA);
          r_perdeu  <= (r_estado == E_COMPARA);
          r_estado  <= (r_estado == E_ESPERA) ? E_TIMEOUT : E_PERDEU;
        end
      end else begin
        unique case (r_estado)
          E_PREPARA: r_estado <= E_ACRESCENTA;
          E_ACRESCENTA: begin
            r_mem[r_k[IW-1:0]] <= w_new;
            r_k      <= r_k + SW'(1);
            r_i      <= '0;
            r_timer  <= '0;
            // mem[0] is only being written now in round one.
            r_leds   <= (r_k == '0) ? f_onehot(w_new) : f_onehot(r_mem[0]);
            r_estado <= E_MOSTRA;
          end
          E_MOSTRA: begin
            if (r_timer >= w_t_led - TW'(1)) begin
              r_timer  <= '0;
              r_estado <= E_APAGADO;
            end else begin
              r_timer <= r_timer + TW'(1);
              r_leds  <= r_leds;
            end
          end
          E_APAGADO: begin
            if (r_timer >= w_t_apag - TW'(1)) begin
              r_timer <= '0;
              if (w_last) begin
                r_i      <= '0;
                r_estado <= E_ESPERA;
              end else begin
                r_i      <= w_i_nxt;
                r_leds   <= f_onehot(r_mem[w_i_nxt[IW-1:0]]);
                r_estado <= E_MOSTRA;
              end
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          E_ESPERA: begin
            if (w_press) begin
              r_press_ok  <= w_onehot;
              r_press_idx <= w_idx;
              r_estado    <= E_COMPARA;
            end else begin
              r_timer <= r_timer + TW'(1);
              r_leds  <= bus.botoes;
            end
          end
          E_COMPARA: begin
            if (!w_last) begin
              r_i      <= w_i_nxt;
              r_timer  <= '0;
              r_estado <= E_PROXIMA;
            end else begin
              r_estado <= E_FIM_RODADA;
            end
          end
          E_PROXIMA: r_estado <= E_ESPERA;
          E_FIM_RODADA: begin
            if (r_score != SW'(PROFUNDIDADE))
              r_score <= r_score + SW'(1);
            if (r_k == SW'(PROFUNDIDADE)) begin
              r_pronto <= 1'b1;
              r_ganhou <= 1'b1;
              r_estado <= E_GANHOU;
            end else begin
              r_estado <= E_ACRESCENTA;
            end
          end
          E_INICIAL, E_GANHOU, E_PERDEU, E_TIMEOUT: r_estado <= r_estado;
          default: r_estado <= E_INICIAL;
        endcase
      end
    end
  end

  assign bus.leds      = r_leds;
  assign bus.score     = r_score;
  assign bus.pronto    = r_pronto;
  assign bus.ganhou    = r_ganhou;
  assign bus.perdeu    = r_perdeu;
  assign bus.timeout   = r_timeout;
  assign bus.db_estado = r_estado;
endmodule

// File: tb/tb_geogenius_param.sv
// Scoreboard bench for geogenius_param: LFSR-driven sequence model,
// replay and end-of-game checks decoupled from the stimulus driver.
module tb_geogenius_param;
  localparam int N  = 8;
  localparam int P  = 16;
  localparam int LG = 3;

  typedef struct {
    logic [3:0] flags;
    int         score;
    int         delay;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  geogenius_param_if #(.N_BOTOES(N), .PROFUNDIDADE(P)) bus();

  geogenius_param #(
    .N_BOTOES(N), .PROFUNDIDADE(P),
    .TEMPO_LED(6), .TEMPO_APAGADO(4),
    .TEMPO_JOGADA(5000), .SEMENTE(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] m_lfsr;
  int seq[$];
  int q_rep[$];
  exp_t q_out[$];
  int prev_st = 0;
  int esp_cyc = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [N-1:0] oh(input int v);
    logic [N-1:0] one;
    one = 1;
    return one << v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);
  end

  // Monitor: builds the expected sequence and checks replay and endings.
  always @(negedge clock) begin
    int st;
    int v;
    exp_t e;
    if (reset) begin
      seq.delete();
      q_rep.delete();
      prev_st = 0;
    end else begin
      st = int'(bus.db_estado);
      if (st == 1 && prev_st != 1) begin
        seq.delete();
        q_rep.delete();
      end
      if (st == 2 && prev_st != 2)
        seq.push_back(int'(m_lfsr[LG-1:0]));
      if (st == 3 && prev_st != 3) begin
        if (prev_st != 4)
          foreach (seq[n]) q_rep.push_back(seq[n]);
        if (q_rep.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL replay_unexpected: leds=%0h", bus.leds);
        end else begin
          v = q_rep.pop_front();
          chk("replay_led", int'(bus.leds), int'(oh(v)));
        end
      end
      if (st == 5 && prev_st != 5) esp_cyc = cyc;
      if (st >= 10 && prev_st < 10) begin
        if (q_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL end_unexpected: state=%0h", st);
        end else begin
          e = q_out.pop_front();
          chk("end_flags", int'({bus.pronto, bus.ganhou,
                                 bus.perdeu, bus.timeout}), int'(e.flags));
          chk("end_score", int'(bus.score), e.score);
          chk("end_leds", int'(bus.leds), 0);
          if (e.delay >= 0) chk("timeout_delay", cyc - esp_cyc, e.delay);
        end
      end
      prev_st = st;
    end
  end

  task automatic wait_state(input int s, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(bus.db_estado) != s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({"wait_", nm}, int'(bus.db_estado), s);
  endtask

  task automatic wait_term(input int budget);
    int n;
    n = 0;
    while (bus.db_estado < 4'hA && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("terminal_reached", int'(bus.db_estado >= 4'hA), 1);
  endtask

  task automatic start_game(input logic dif);
    @(negedge clock);
    bus.dificuldade = dif;
    bus.jogar       = 1'b1;
    @(negedge clock);
    bus.jogar       = 1'b0;
  endtask

  task automatic press(input logic [N-1:0] b);
    int n;
    repeat ($urandom_range(0, 3)) @(negedge clock);
    bus.botoes = b;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.db_estado == 4'h5 && n < 8);
    chk("press_taken", int'(bus.db_estado != 4'h5), 1);
    repeat ($urandom_range(0, 1)) @(negedge clock);
    bus.botoes = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic play_round(input int k, input int wrong_at, input bit hold);
    logic [N-1:0] b;
    int budget;
    budget = k * 20 + 100;
    if (hold) begin
      wait_state(3, budget, "mostra_hold");
      b = oh(seq[0]);
      @(negedge clock);
      bus.botoes = b;
      wait_state(5, budget, "espera_hold");
      repeat (10) @(negedge clock);
      chk("held_no_compara", int'(bus.db_estado), 5);
      chk("held_echo", int'(bus.leds), int'(b));
      bus.botoes = '0;
      repeat (2) @(negedge clock);
    end
    for (int j = 0; j < k; j++) begin
      wait_state(5, budget, "espera");
      if (j == wrong_at)
        b = oh((seq[j] + int'($urandom_range(1, N - 1))) % N);
      else
        b = oh(seq[j]);
      press(b);
      if (j == wrong_at) break;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bus.jogar       = 1'b0;
    bus.dificuldade = 1'b0;
    bus.botoes      = '0;
    reset           = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_state", int'(bus.db_estado), 0);
    chk("rst_leds", int'(bus.leds), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_flags", int'({bus.pronto, bus.ganhou,
                           bus.perdeu, bus.timeout}), 0);

    // Reset in the middle of round 2 replay.
    start_game(1'b0);
    play_round(1, -1, 1'b0);
    wait_state(3, 200, "mostra_r2");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_state", int'(bus.db_estado), 0);
    chk("midrst_leds", int'(bus.leds), 0);
    chk("midrst_score", int'(bus.score), 0);
    chk("midrst_flags", int'({bus.pronto, bus.ganhou,
                              bus.perdeu, bus.timeout}), 0);

    // Full winning game; round 2 holds a button into ESPERA.
    start_game(1'b0);
    for (int r = 1; r <= P; r++) begin
      if (r == P) begin
        e.flags = 4'b1100;
        e.score = P;
        e.delay = -1;
        q_out.push_back(e);
      end
      play_round(r, -1, r == 2);
    end
    wait_term(50);
`ifdef GEOGENIUS_VIDAS_EN
    chk("win_vidas", int'(bus.vidas), 3);
`endif
    start_game(1'b0);
    chk("restart_state", int'(bus.db_estado), 1);
    chk("restart_score", int'(bus.score), 0);
    chk("restart_flags", int'({bus.pronto, bus.ganhou,
                               bus.perdeu, bus.timeout}), 0);

`ifdef GEOGENIUS_VIDAS_EN
    // Three wrong presses in round 1 with lives.
    wait_state(5, 100, "v3");
    chk("vidas3", int'(bus.vidas), 3);
    press(oh((seq[0] + 1) % N));
    wait_state(5, 100, "v2");
    chk("vidas2", int'(bus.vidas), 2);
    press(oh((seq[0] + 2) % N));
    wait_state(5, 100, "v1");
    chk("vidas1", int'(bus.vidas), 1);
    e.flags = 4'b1010;
    e.score = 0;
    e.delay = -1;
    q_out.push_back(e);
    press(oh((seq[0] + 3) % N));
    wait_term(50);
`else
    // Round 3, second press wrong.
    play_round(1, -1, 1'b0);
    play_round(2, -1, 1'b0);
    e.flags = 4'b1010;
    e.score = 2;
    e.delay = -1;
    q_out.push_back(e);
    play_round(3, 1, 1'b0);
    wait_term(50);

    // Hard mode, no press: timeout after halved TEMPO_JOGADA.
    e.flags = 4'b1001;
    e.score = 0;
    e.delay = 2500;
    q_out.push_back(e);
    start_game(1'b1);
    wait_term(3000);

    // Two buttons at once is a wrong press.
    start_game(1'b0);
    wait_state(5, 100, "two_btn");
    e.flags = 4'b1010;
    e.score = 0;
    e.delay = -1;
    q_out.push_back(e);
    press(8'b0000_0101 << $urandom_range(0, 5));
    wait_term(50);
`endif

    repeat (2) @(negedge clock);
    chk("pending_outcomes", q_out.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
